// File: rtl/pdm_mic_frontend_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_mic_frontend_if: MEMS mic pins plus PCM output bundle.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pdm_mic_frontend_if #(
  parameter int OUT_WIDTH = 32
);
  logic                        MIC_DATA;
  logic                        MIC_CLK;
  logic                        m_clk_rising;
  logic signed [OUT_WIDTH-1:0] pcm_data;
  logic                        pcm_data_valid;

  modport master (
    input  MIC_DATA,
    output MIC_CLK,
    output m_clk_rising,
    output pcm_data,
    output pcm_data_valid
  );

  modport slave (
    output MIC_DATA,
    input  MIC_CLK,
    input  m_clk_rising,
    input  pcm_data,
    input  pcm_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/pdm_mic_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_mic_frontend: mic bit-clock divider, PDM sampler, CIC decimator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdm_mic_frontend #(
  parameter int IN_FREQ   = 100_000_000,
  parameter int OUT_FREQ  = 480_000,
  parameter int DECIM     = 10,
  parameter int CIC_ORDER = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  pdm_mic_frontend_if.master  mic
);

  localparam int HALF  = IN_FREQ / (2 * OUT_FREQ);
  localparam int CW    = 2 + $clog2(DECIM ** CIC_ORDER);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DIV_W-1:0] C_HALF_LAST = DIV_W'(HALF - 1);
  localparam logic [DEC_W-1:0] C_DEC_LAST  = DEC_W'(DECIM - 1);

  if (HALF < 4) begin : g_chk_half
    $error("pdm_mic_frontend: IN_FREQ/(2*OUT_FREQ) must be at least 4");
  end
  if (OUT_WIDTH < CW) begin : g_chk_width
    $error("pdm_mic_frontend: OUT_WIDTH narrower than CIC internal width");
  end

  logic [DIV_W-1:0]        r_div;
  logic                    r_mic_clk;
  logic                    r_rise;
  logic [1:0]              r_sync;
  logic [DEC_W-1:0]        r_dec;
  logic signed [CW-1:0]    r_int [CIC_ORDER];
  logic signed [CW-1:0]    r_dly [CIC_ORDER];
  logic signed [CW-1:0]    r_cap;
  logic                    r_cap_vld;
  logic signed [OUT_WIDTH-1:0] r_pcm;
  logic                    r_pcm_vld;

  logic signed [1:0]       w_pdm;
  logic signed [CW-1:0]    w_int_acc;
  logic signed [CW-1:0]    w_int_nxt [CIC_ORDER];
  logic signed [CW-1:0]    w_comb_acc;
  logic signed [CW-1:0]    w_dly_nxt [CIC_ORDER];

  // 1 -> +1 (01), 0 -> -1 (11)
  assign w_pdm = {~r_sync[1], 1'b1};

  // Integrator cascade: every stage sees the freshly updated previous stage.
  always_comb begin
    w_int_acc = CW'(w_pdm);
    w_int_nxt = r_int;
    for (int k = 0; k < CIC_ORDER; k++) begin
      w_int_acc    = r_int[k] + w_int_acc;
      w_int_nxt[k] = w_int_acc;
    end
  end

  // Comb cascade; each stage input becomes that stage's stored delay.
  always_comb begin
    w_comb_acc = r_cap;
    w_dly_nxt  = r_dly;
    for (int k = 0; k < CIC_ORDER; k++) begin
      w_dly_nxt[k] = w_comb_acc;
      w_comb_acc   = w_comb_acc - r_dly[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
      r_rise    <= 1'b0;
      r_sync    <= '0;
      r_dec     <= '0;
      r_int     <= '{default: '0};
      r_dly     <= '{default: '0};
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
      r_pcm     <= '0;
      r_pcm_vld <= 1'b0;
    end else begin
      r_rise    <= 1'b0;
      r_cap_vld <= 1'b0;
      r_pcm_vld <= 1'b0;
      r_sync    <= {r_sync[0], mic.MIC_DATA};

      if (r_div == C_HALF_LAST) begin
        r_div     <= '0;
        r_mic_clk <= ~r_mic_clk;
        r_rise    <= ~r_mic_clk;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (r_rise) begin
        r_int <= w_int_nxt;
        if (r_dec == C_DEC_LAST) begin
          r_dec     <= '0;
          r_cap     <= w_int_nxt[CIC_ORDER-1];
          r_cap_vld <= 1'b1;
        end else begin
          r_dec <= r_dec + 1'b1;
        end
      end

      if (r_cap_vld) begin
        r_dly     <= w_dly_nxt;
        r_pcm     <= OUT_WIDTH'(w_comb_acc);
        r_pcm_vld <= 1'b1;
      end
    end
  end

  assign mic.MIC_CLK        = r_mic_clk;
  assign mic.m_clk_rising   = r_rise;
  assign mic.pcm_data       = r_pcm;
  assign mic.pcm_data_valid = r_pcm_vld;

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pdm_mic_frontend: directed checks of divider, latency and CIC gain.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pdm_mic_frontend;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pdm_mic_frontend_if #(.OUT_WIDTH(32)) mic ();

  pdm_mic_frontend #(
    .IN_FREQ   (100_000_000),
    .OUT_FREQ  (480_000),
    .DECIM     (10),
    .CIC_ORDER (4),
    .OUT_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mic (mic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic first_bit);
    @(negedge clk);
    rst = 1'b1;
    mic.MIC_DATA = first_bit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs until 5 valids; pattern bit advances after every m_clk_rising.
  task automatic run_case(input string tag, input logic [7:0] pat,
                          input int len, input logic signed [31:0] exp);
    int cyc;
    int v;
    int idx;
    int last;
    bit hold;
    cyc  = 0;
    v    = 0;
    idx  = 0;
    last = 0;
    hold = 1'b0;
    do_reset(pat[0]);
    while (v < 5 && cyc < 12000) begin
      step();
      cyc++;
      if (hold) begin
        chk({tag, "_hold_valid"}, 32'(mic.pcm_data_valid), 0);
        chk({tag, "_hold_pcm"}, mic.pcm_data, exp);
        hold = 1'b0;
      end
      if (mic.m_clk_rising) begin
        idx = (idx + 1) % len;
        mic.MIC_DATA = pat[idx];
      end
      if (mic.pcm_data_valid) begin
        v++;
        if (v == 1) chk({tag, "_first_valid_cyc"}, cyc, 1978);
        else        chk({tag, "_valid_interval"}, cyc - last, 2080);
        if (v >= 4) chk({tag, "_pcm"}, mic.pcm_data, exp);
        if (v == 4) hold = 1'b1;
        last = cyc;
      end
    end
    if (v < 5) chk({tag, "_timeout_valids"}, v, 5);
  endtask

  initial begin
    int n;
    int h;
    int l;
    int rises;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mic.MIC_DATA = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_mic_clk", 32'(mic.MIC_CLK), 0);
    chk("rst_rise", 32'(mic.m_clk_rising), 0);
    chk("rst_pcm", mic.pcm_data, 0);
    chk("rst_valid", 32'(mic.pcm_data_valid), 0);

    // Divider timing
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!mic.m_clk_rising && n < 2000);
    chk("first_rise_cyc", n, 104);
    chk("mic_clk_at_rise", 32'(mic.MIC_CLK), 1);
    h = 0;
    while (mic.MIC_CLK === 1'b1 && h < 1000) begin
      step();
      h++;
      if (h == 1) chk("rise_pulse_width", 32'(mic.m_clk_rising), 0);
    end
    chk("mic_clk_high", h, 104);
    l = 0;
    while (mic.MIC_CLK === 1'b0 && l < 1000) begin
      step();
      l++;
    end
    chk("mic_clk_low", l, 104);
    chk("second_rise", 32'(mic.m_clk_rising), 1);

    // CIC responses
    run_case("const1", 8'b0000_0001, 1, 32'sd10000);
    run_case("const0", 8'b0000_0000, 1, -32'sd10000);
    run_case("toggle", 8'b0000_0001, 2, 32'sd0);
    run_case("p11110", 8'b0000_1111, 5, 32'sd6000);

    // One-cycle reset landing on the cycle a valid would have fired
    do_reset(1'b1);
    rises = 0;
    n = 0;
    while (rises < 20 && n < 6000) begin
      step();
      n++;
      if (mic.m_clk_rising) rises++;
    end
    chk("mid_rises_seen", rises, 20);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_mic_clk", 32'(mic.MIC_CLK), 0);
    chk("mid_rst_rise", 32'(mic.m_clk_rising), 0);
    chk("mid_rst_pcm", mic.pcm_data, 0);
    chk("mid_rst_valid", 32'(mic.pcm_data_valid), 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!mic.pcm_data_valid && n < 4000);
    chk("mid_rst_first_valid_cyc", n, 1978);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
